// File: rtl/mem_responder.sv
// Word-addressed RAM slave for the req/gnt/rvalid bus, with configurable grant delay and response latency.
// Define MEM_RESPONDER_RANGE_ERR_EN to flag out-of-range addresses with err_o and suppress their writes.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_DELAY);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic             gnt_c;
  logic             full_c;
  logic [IDX_W-1:0] idx_c;
  logic             oor_c;
  logic [31:0]      rd_data_c;
  logic             unused_c;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        vld_q [RESP_LATENCY];
  logic [31:0] dat_q [RESP_LATENCY];
  logic        err_q [RESP_LATENCY];

  assign idx_c    = addr_i[2 +: IDX_W];
  assign unused_c = ^addr_i;

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic [31:0] addr_hi_c;
  assign addr_hi_c = addr_i >> (IDX_W + 2);
  assign oor_c     = |addr_hi_c;
`else
  assign oor_c = 1'b0;
`endif

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign full_c = (outst_q == OUT_MAX) && !rvalid_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      outst_q    <= outst_d;
    end
  end

  // Grant FSM: counts consecutive req cycles up to GNT_DELAY, then grants when a slot is free.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            gnt_c = !full_c;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if ((wait_cnt_q == CNT_MAX) && !full_c) begin
          gnt_c      = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
    if (reset) begin
      gnt_c = 1'b0;
    end
  end

  assign gnt_o = gnt_c;

  always_comb begin
    outst_d = outst_q;
    if (gnt_c && !rvalid_o && (outst_q != OUT_MAX)) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!gnt_c && rvalid_o && (outst_q != '0)) begin
      outst_d = outst_q - OUT_W'(1);
    end
  end

  // RAM is never reset; writes land on the grant edge so later grants see them.
  always_ff @(posedge clk) begin
    if (gnt_c && we_i && !oor_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_c][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_c = (we_i || oor_c) ? 32'h0 : mem_q[idx_c];

  // Response pipeline; empty stages carry zero data so outputs are clean when rvalid_o is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < RESP_LATENCY; s++) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
        err_q[s] <= 1'b0;
      end
    end else begin
      vld_q[0] <= gnt_c;
      dat_q[0] <= gnt_c ? rd_data_c : 32'h0;
      err_q[0] <= gnt_c && oor_c;
      for (int s = 1; s < RESP_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
        err_q[s] <= err_q[s-1];
      end
    end
  end

  assign rvalid_o = vld_q[RESP_LATENCY-1];
  assign rdata_o  = dat_q[RESP_LATENCY-1];
  assign err_o    = err_q[RESP_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (default timing, delayed grant, deep latency) with
// vector tables, hand-timed corner sequences and a queue-based reference model under random traffic.
module tb_mem_responder;

  localparam int NDUT    = 3;
  localparam int C_LAT   = 3;
  localparam int C_MAX   = 2;
  localparam int C_DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        req   [NDUT];
  logic [31:0] addr  [NDUT];
  logic        we    [NDUT];
  logic [3:0]  be    [NDUT];
  logic [31:0] wdata [NDUT];
  logic        gnt   [NDUT];
  logic        rvalid[NDUT];
  logic [31:0] rdata [NDUT];
  logic        err   [NDUT];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .reset(reset), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  mem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(3), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .reset(reset), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  mem_responder #(.DEPTH_WORDS(C_DEPTH), .GNT_DELAY(0), .RESP_LATENCY(C_LAT), .MAX_OUTSTANDING(C_MAX)) u_c (
    .clk(clk), .reset(reset), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table for instance a ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model for instance c ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_t;
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rq_t         rq_q[$];
  rsp_t        pend_q[$];
  logic [31:0] mdl_mem [C_DEPTH];
  bit          glog[$];
  bit          vlog[$];

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    return (a >> 6) != 32'h0;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic void push_rq(input logic w, input logic [31:0] a, input logic [3:0] b,
                                  input logic [31:0] d);
    rq_t r;
    r.we = w; r.addr = a; r.be = b; r.wdata = d;
    rq_q.push_back(r);
  endfunction

  // Drives queued requests into instance c and checks every cycle against the model.
  task automatic run_c(input int budget);
    rq_t  r;
    rsp_t s;
    bit   active;
    bit   retire;
    bit   full;
    bit   exp_g;
    int   cyc;
    int   idx;
    active = 1'b0;
    cyc    = 0;
    glog.delete();
    vlog.delete();
    while ((rq_q.size() > 0 || active || pend_q.size() > 0) && cyc < budget) begin
      if (!active && rq_q.size() > 0) begin
        r        = rq_q.pop_front();
        req[2]   = 1'b1;
        we[2]    = r.we;
        addr[2]  = r.addr;
        be[2]    = r.be;
        wdata[2] = r.wdata;
        active   = 1'b1;
      end
      @(negedge clk);
      retire = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      full   = (pend_q.size() == C_MAX) && !retire;
      exp_g  = active && !full;
      glog.push_back(gnt[2]);
      vlog.push_back(rvalid[2]);
      chk($sformatf("c gnt cyc%0d", cyc), 32'(gnt[2]), 32'(exp_g));
      if (retire) begin
        s = pend_q.pop_front();
        chk($sformatf("c rvalid cyc%0d", cyc), 32'(rvalid[2]), 32'd1);
        chk($sformatf("c rdata cyc%0d", cyc), rdata[2], s.data);
        chk($sformatf("c err cyc%0d", cyc), 32'(err[2]), 32'(s.err));
      end else begin
        chk($sformatf("c idle rvalid cyc%0d", cyc), 32'(rvalid[2]), 32'd0);
        chk($sformatf("c idle rdata cyc%0d", cyc), rdata[2], 32'd0);
      end
      if (exp_g) begin
        idx   = int'((r.addr >> 2) % C_DEPTH);
        s.err = is_oor(r.addr);
        if (r.we) begin
          if (!s.err) begin
            for (int b = 0; b < 4; b++) begin
              if (r.be[b]) mdl_mem[idx][8*b +: 8] = r.wdata[8*b +: 8];
            end
          end
          s.data = 32'h0;
        end else begin
          s.data = s.err ? 32'h0 : mdl_mem[idx];
        end
        s.due = cyc + C_LAT;
        pend_q.push_back(s);
        active = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!active) req[2] = 1'b0;
      cyc++;
    end
    if (rq_q.size() > 0 || active || pend_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL c drain: %0d requests still pending after %0d cycles", rq_q.size() + pend_q.size(), budget);
      rq_q.delete();
      pend_q.delete();
      req[2] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit exp_gc[8];
    bit exp_vc[8];
    logic [31:0] a;

    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset gnt%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("reset rvalid%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("reset rdata%0d", k), rdata[k], 32'd0);
      chk($sformatf("reset err%0d", k), 32'(err[k]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Instance a: same-cycle grant, one-cycle response.
    add(1'b1, 32'h10,    4'hF, 32'hDEADBEEF, 32'h0,        1'b0);
    add(1'b0, 32'h10,    4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h20,    4'hF, 32'hAAAAAAAA, 32'h0,        1'b0);
    add(1'b1, 32'h20,    4'h5, 32'h11223344, 32'h0,        1'b0);
    add(1'b0, 32'h20,    4'h0, 32'h0,        32'hAA22AA44, 1'b0);
    add(1'b1, 32'h20,    4'h0, 32'hFFFFFFFF, 32'h0,        1'b0);
    add(1'b0, 32'h22,    4'h0, 32'h0,        32'hAA22AA44, 1'b0);
    add(1'b1, 32'h0,     4'hF, 32'h12345678, 32'h0,        1'b0);
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    add(1'b1, 32'h10000, 4'hF, 32'hCAFEF00D, 32'h0,        1'b1);
    add(1'b0, 32'h0,     4'h0, 32'h0,        32'h12345678, 1'b0);
    add(1'b0, 32'h10000, 4'h0, 32'h0,        32'h0,        1'b1);
`else
    add(1'b1, 32'h10000, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0);
    add(1'b0, 32'h0,     4'h0, 32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b0, 32'h10000, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0);
`endif
    add(1'b0, 32'h10,    4'h0, 32'h0,        32'hDEADBEEF, 1'b0);

    foreach (vecs[i]) begin
      req[0] = 1'b1; we[0] = vecs[i].we; addr[0] = vecs[i].addr;
      be[0] = vecs[i].be; wdata[0] = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("a%0d gnt", i), 32'(gnt[0]), 32'd1);
      chk($sformatf("a%0d early rvalid", i), 32'(rvalid[0]), 32'd0);
      @(posedge clk);
      #1 req[0] = 1'b0;
      @(negedge clk);
      chk($sformatf("a%0d rvalid", i), 32'(rvalid[0]), 32'd1);
      chk($sformatf("a%0d rdata", i), rdata[0], vecs[i].exp_rdata);
      chk($sformatf("a%0d err", i), 32'(err[0]), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1;
    end

    // Instance b: req held from cycle 0 -> grant at 3, rvalid at 7.
    we[1] = 1'b0; addr[1] = 32'h40; be[1] = 4'h0; wdata[1] = '0;
    for (int c = 0; c < 10; c++) begin
      req[1] = (c <= 3);
      @(negedge clk);
      chk($sformatf("b held gnt cyc%0d", c), 32'(gnt[1]), 32'(c == 3));
      chk($sformatf("b held rvalid cyc%0d", c), 32'(rvalid[1]), 32'(c == 7));
      @(posedge clk);
      #1;
    end
    // Instance b: req dropped at cycle 2 -> nothing at all.
    for (int c = 0; c < 10; c++) begin
      req[1] = (c < 2);
      @(negedge clk);
      chk($sformatf("b drop gnt cyc%0d", c), 32'(gnt[1]), 32'd0);
      chk($sformatf("b drop rvalid cyc%0d", c), 32'(rvalid[1]), 32'd0);
      @(posedge clk);
      #1;
    end

    // Instance c: preload every word, then four back-to-back reads.
    for (int w = 0; w < C_DEPTH; w++) push_rq(1'b1, 32'(w * 4), 4'hF, $urandom);
    run_c(200);
    for (int w = 0; w < 4; w++) push_rq(1'b0, 32'(w * 4), 4'h0, 32'h0);
    run_c(50);
    exp_gc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("c burst gnt cyc%0d", c), 32'(glog[c]), 32'(exp_gc[c]));
      chk($sformatf("c burst rvalid cyc%0d", c), 32'(vlog[c]), 32'(exp_vc[c]));
    end

    // Reset one cycle after a read grant drops the response; RAM survives.
    push_rq(1'b1, 32'h30, 4'hF, 32'h5A5A1234);
    run_c(50);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h30; be[2] = 4'h0;
    @(negedge clk);
    chk("rst gnt before reset", 32'(gnt[2]), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst gnt forced low", 32'(gnt[2]), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    req[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst dropped rvalid cyc%0d", c), 32'(rvalid[2]), 32'd0);
      @(posedge clk);
      #1;
    end
    push_rq(1'b0, 32'h30, 4'h0, 32'h0);
    run_c(50);

    // Random traffic, occasionally with upper address bits set.
    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, C_DEPTH - 1)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 8);
      push_rq(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
    end
    run_c(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
